// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue stage: ALU select codes, RV64I opcodes
// and the funct3-to-alusel mapping.
package alu_issue_pkg;

  typedef enum logic [3:0] {
    SEL_ADD  = 4'd0,
    SEL_SUB  = 4'd1,
    SEL_SLL  = 4'd2,
    SEL_SLT  = 4'd3,
    SEL_SLTU = 4'd4,
    SEL_XOR  = 4'd5,
    SEL_SRL  = 4'd6,
    SEL_SRA  = 4'd7,
    SEL_OR   = 4'd8,
    SEL_AND  = 4'd9
  } alusel_e;

  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;

  // alt_sub selects SUB for funct3=000, alt_sra selects SRA for funct3=101
  function automatic alusel_e f3_sel(input logic [2:0] f3,
                                     input logic alt_sub,
                                     input logic alt_sra);
    alusel_e s;
    case (f3)
      3'b000:  s = alt_sub ? SEL_SUB : SEL_ADD;
      3'b001:  s = SEL_SLL;
      3'b010:  s = SEL_SLT;
      3'b011:  s = SEL_SLTU;
      3'b100:  s = SEL_XOR;
      3'b101:  s = alt_sra ? SEL_SRA : SEL_SRL;
      3'b110:  s = SEL_OR;
      default: s = SEL_AND;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/alu_issue_imm_gen.sv
// Immediate generator: builds sign-extended I-type and U-type immediates
// from the upper instruction bits inst[31:12].
module imm_gen #(
  parameter int unsigned XLEN = 64
) (
  input  logic [19:0]     inst_hi,
  output logic [XLEN-1:0] iimm,
  output logic [XLEN-1:0] uimm
);

  // inst_hi[19] is inst[31], the sign bit of both formats
  assign iimm = {{(XLEN-12){inst_hi[19]}}, inst_hi[19:8]};
  assign uimm = {{(XLEN-32){inst_hi[19]}}, inst_hi, 12'h000};

endmodule

// File: rtl/alu_issue.sv
// Decode/issue stage in front of the integer ALU: decodes an RV64I integer
// instruction into ALU operands and select, registered with valid/ready.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] x,
  output logic [XLEN-1:0] y,
  output logic [3:0]      alusel,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic            word_op,
  output logic            illegal
);

  logic            accept;
  logic [XLEN-1:0] iimm, uimm, wx;
  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic            inst30, is_shift, f7_ok, shimm_ok, w_f3_ok;
  logic [XLEN-1:0] d_x, d_y;
  alusel_e         d_sel;
  logic            d_word, d_ill;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst_hi (in_inst[31:12]),
    .iimm    (iimm),
    .uimm    (uimm)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  assign opc      = in_inst[6:0];
  assign f3       = in_inst[14:12];
  assign f7       = in_inst[31:25];
  assign inst30   = in_inst[30];
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
  assign f7_ok    = (f7 == 7'b0000000) ||
                    ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
  assign shimm_ok = (in_inst[31:26] == 6'b000000) || (in_inst[31:26] == 6'b010000);
  assign w_f3_ok  = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b101);

  // Word right shifts take the low word zero- or sign-extended by shift kind
  assign wx = (f3 != 3'b101) ? rs1_data :
              inst30 ? {{(XLEN-32){rs1_data[31]}}, rs1_data[31:0]}
                     : {{(XLEN-32){1'b0}}, rs1_data[31:0]};

  always_comb begin
    d_x    = '0;
    d_y    = '0;
    d_sel  = SEL_ADD;
    d_word = 1'b0;
    d_ill  = 1'b0;
    case (opc)
      OPC_OP: begin
        d_x   = rs1_data;
        d_y   = is_shift ? {{(XLEN-6){1'b0}}, rs2_data[5:0]} : rs2_data;
        d_sel = f3_sel(f3, inst30, inst30);
        d_ill = !f7_ok;
      end
      OPC_OPIMM: begin
        d_x   = rs1_data;
        d_y   = is_shift ? {{(XLEN-6){1'b0}}, in_inst[25:20]} : iimm;
        d_sel = f3_sel(f3, 1'b0, inst30);
        d_ill = is_shift && !shimm_ok;
      end
      OPC_LUI: begin
        d_y = uimm;
      end
      OPC_AUIPC: begin
        d_x = in_pc;
        d_y = uimm;
      end
      OPC_OP32: begin
        d_word = 1'b1;
        d_x    = wx;
        d_y    = is_shift ? {{(XLEN-5){1'b0}}, rs2_data[4:0]} : rs2_data;
        d_sel  = f3_sel(f3, inst30, inst30);
        d_ill  = !f7_ok || !w_f3_ok;
      end
      OPC_OPIMM32: begin
        d_word = 1'b1;
        d_x    = wx;
        d_y    = is_shift ? {{(XLEN-5){1'b0}}, in_inst[24:20]} : iimm;
        d_sel  = f3_sel(f3, 1'b0, inst30);
        d_ill  = !w_f3_ok || (is_shift && (!shimm_ok || in_inst[25]));
      end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_x   = '0;
      d_y   = '0;
      d_sel = SEL_ADD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      x         <= '0;
      y         <= '0;
      alusel    <= SEL_ADD;
      rd        <= '0;
      rd_we     <= 1'b0;
      word_op   <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= flush ? 1'b0 : accept ? 1'b1 : (out_ready ? 1'b0 : out_valid);
      if (accept) begin
        x       <= d_x;
        y       <= d_y;
        alusel  <= d_sel;
        rd      <= in_inst[11:7];
        rd_we   <= !d_ill && (in_inst[11:7] != 5'd0);
        word_op <= d_word;
        illegal <= d_ill;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue.
module tb_alu_issue;

  localparam logic [3:0] E_ADD = 4'd0, E_SLL = 4'd2, E_SRL = 4'd6, E_SRA = 4'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [63:0] in_pc = '0;
  logic [63:0] rs1_data = '0;
  logic [63:0] rs2_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] x, y;
  logic [3:0]  alusel;
  logic [4:0]  rd;
  logic        rd_we, word_op, illegal;

  int total = 0;
  int bad = 0;

  alu_issue #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .x(x), .y(y), .alusel(alusel), .rd(rd), .rd_we(rd_we),
    .word_op(word_op), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic drive(input logic [31:0] inst, input logic [63:0] pc,
                       input logic [63:0] a, input logic [63:0] b);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    rs1_data = a;
    rs2_data = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    total++; if (x !== 64'd0 || y !== 64'd0) begin bad++; $display("FAIL rst_xy got=%h/%h exp=0/0", x, y); end
    total++; if (alusel !== E_ADD || rd !== 5'd0) begin bad++; $display("FAIL rst_sel_rd got=%0d/%0d exp=0/0", alusel, rd); end
    total++; if ({rd_we, word_op, illegal} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {rd_we, word_op, illegal}); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    drive(32'h002081B3, 64'h0, 64'd5, 64'd7);
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", out_valid); end
    total++; if (alusel !== E_ADD) begin bad++; $display("FAIL add_sel got=%0d exp=%0d", alusel, E_ADD); end
    total++; if (x !== 64'd5 || y !== 64'd7) begin bad++; $display("FAIL add_xy got=%h/%h exp=5/7", x, y); end
    total++; if (rd !== 5'd3 || rd_we !== 1'b1) begin bad++; $display("FAIL add_rd got=%0d/%b exp=3/1", rd, rd_we); end
    total++; if (word_op !== 1'b0 || illegal !== 1'b0) begin bad++; $display("FAIL add_flags got=%b/%b exp=0/0", word_op, illegal); end
  endtask

  task automatic test_shift();
    drive(32'h43F35293, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0);
    step();
    total++; if (alusel !== E_SRA) begin bad++; $display("FAIL srai_sel got=%0d exp=%0d", alusel, E_SRA); end
    total++; if (x !== 64'hFFFF_FFFF_FFFF_FFF8) begin bad++; $display("FAIL srai_x got=%h exp=fffffffffffffff8", x); end
    total++; if (y !== 64'd63 || rd !== 5'd5) begin bad++; $display("FAIL srai_y_rd got=%h/%0d exp=3f/5", y, rd); end
    // sll x1,x2,x3 with rs2=0x41
    drive(32'h003110B3, 64'h0, 64'd9, 64'h41);
    step();
    total++; if (alusel !== E_SLL || y !== 64'd1) begin bad++; $display("FAIL sll_mask got=%0d/%h exp=2/1", alusel, y); end
    // srlw x1,x2,x3
    drive(32'h003150BB, 64'h0, 64'h1234_5678_8000_0000, 64'h3F);
    step();
    total++; if (alusel !== E_SRL || word_op !== 1'b1) begin bad++; $display("FAIL srlw_sel got=%0d/%b exp=6/1", alusel, word_op); end
    total++; if (x !== 64'h0000_0000_8000_0000 || y !== 64'h1F) begin bad++; $display("FAIL srlw_xy got=%h/%h exp=80000000/1f", x, y); end
    // sraw x1,x2,x3
    drive(32'h403150BB, 64'h0, 64'h1234_5678_8000_0000, 64'h3F);
    step();
    in_valid = 1'b0;
    total++; if (alusel !== E_SRA || x !== 64'hFFFF_FFFF_8000_0000) begin bad++; $display("FAIL sraw got=%0d/%h exp=7/ffffffff80000000", alusel, x); end
  endtask

  task automatic test_upper();
    drive(32'h800000B7, 64'h0, 64'hAAAA, 64'hBBBB);
    step();
    total++; if (x !== 64'd0 || y !== 64'hFFFF_FFFF_8000_0000) begin bad++; $display("FAIL lui_xy got=%h/%h exp=0/ffffffff80000000", x, y); end
    total++; if (alusel !== E_ADD || rd !== 5'd1) begin bad++; $display("FAIL lui_sel got=%0d/%0d exp=0/1", alusel, rd); end
    // auipc x2,1 at pc 0x1000
    drive(32'h00001117, 64'h1000, 64'd0, 64'd0);
    step();
    in_valid = 1'b0;
    total++; if (x !== 64'h1000 || y !== 64'h1000 || rd !== 5'd2) begin bad++; $display("FAIL auipc got=%h/%h/%0d exp=1000/1000/2", x, y, rd); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", out_valid); end
    out_ready = 1'b0;
    drive(32'h002081B3, 64'h0, 64'd5, 64'd7);
    step();
    // addi x4,x1,-1
    drive(32'hFFF08213, 64'h0, 64'd10, 64'd0);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_in_ready got=%b exp=0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (out_valid !== 1'b1 || x !== 64'd5 || y !== 64'd7 || rd !== 5'd3) begin bad++; $display("FAIL b2b_hold%0d got=%b/%h/%h/%0d exp=1/5/7/3", i, out_valid, x, y, rd); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall%0d got=%b exp=0", i, in_ready); end
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || x !== 64'd10 || y !== 64'hFFFF_FFFF_FFFF_FFFF || rd !== 5'd4) begin bad++; $display("FAIL b2b_second got=%b/%h/%h/%0d exp=1/a/ffffffffffffffff/4", out_valid, x, y, rd); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_nodup got=%b exp=0", out_valid); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    drive(32'h023100B3, 64'h0, 64'd3, 64'd4);
    step();
    total++; if (out_valid !== 1'b1 || illegal !== 1'b1 || rd_we !== 1'b0) begin bad++; $display("FAIL mul_ill got=%b/%b/%b exp=1/1/0", out_valid, illegal, rd_we); end
    total++; if (x !== 64'd0 || y !== 64'd0 || alusel !== E_ADD) begin bad++; $display("FAIL mul_zero got=%h/%h/%0d exp=0/0/0", x, y, alusel); end
    drive(32'h00000083, 64'h0, 64'd3, 64'd4);
    step();
    total++; if (illegal !== 1'b1 || rd_we !== 1'b0) begin bad++; $display("FAIL load_ill got=%b/%b exp=1/0", illegal, rd_we); end
    drive(32'h00000013, 64'h0, 64'd0, 64'd0);
    step();
    in_valid = 1'b0;
    total++; if (illegal !== 1'b0 || rd_we !== 1'b0 || rd !== 5'd0) begin bad++; $display("FAIL nop got=%b/%b/%0d exp=0/0/0", illegal, rd_we, rd); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(32'h002081B3, 64'h0, 64'd5, 64'd7);
    step();
    drive(32'hFFF08213, 64'h0, 64'd10, 64'd0);
    flush = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_stay got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    drive(32'h003150BB, 64'h0, 64'h1234_5678_8000_0000, 64'h3F);
    step();
    drive(32'h002081B3, 64'h0, 64'd5, 64'd7);
    step();
    total++; if (out_valid !== 1'b1 || word_op !== 1'b1) begin bad++; $display("FAIL stall_pre got=%b/%b exp=1/1", out_valid, word_op); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
    total++; if (x !== 64'd0 || y !== 64'd0 || alusel !== E_ADD || rd !== 5'd0) begin bad++; $display("FAIL arst_data got=%h/%h/%0d/%0d exp=0/0/0/0", x, y, alusel, rd); end
    total++; if ({rd_we, word_op, illegal} !== 3'b000) begin bad++; $display("FAIL arst_flags got=%b exp=000", {rd_we, word_op, illegal}); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_shift();
    test_upper();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_reset_mid_stall();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
